// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction size and
// IF/ID record field widths, reused by decode and the hazard unit.
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQUEST = 2'd1,
      S_HOLD    = 2'd2,
      S_DRAIN   = 2'd3
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;
   localparam int unsigned IFID_ADDR_W = 32;
   localparam int unsigned IFID_DATA_W = 32;

endpackage

// File: rtl/instruction_fetch_ifid_register.sv
// IF/ID pipeline register: valid/instr/pc/pcPlus4 with clear, load and hold.
// Priority is reset, clear, load, hold; with none of them the entry becomes a bubble.
module ifid_register
   import instruction_fetch_pkg::*;
#(
   parameter int ADDR_W = IFID_ADDR_W,
   parameter int DATA_W = IFID_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic              i_hold,
   input  logic [DATA_W-1:0] i_instr,
   input  logic [ADDR_W-1:0] i_pc,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_pc,
   output logic [ADDR_W-1:0] o_pcPlus4
);

   always_ff @(posedge clk) begin
      if (reset) begin
         o_valid   <= 1'b0;
         o_instr   <= '0;
         o_pc      <= '0;
         o_pcPlus4 <= '0;
      end else if (i_clear) begin
         o_valid <= 1'b0;
      end else if (i_load) begin
         o_valid   <= 1'b1;
         o_instr   <= i_instr;
         o_pc      <= i_pc;
         o_pcPlus4 <= i_pc + ADDR_W'(INSTR_BYTES);
      end else if (!i_hold) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: ready-based instruction memory handshake, one-entry skid
// buffer for decode stalls, and flush handling that never abandons a request.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int ADDR_W = IFID_ADDR_W,
   parameter int DATA_W = IFID_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pcAddress,
   output logic              pcAdvance,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   input  logic              memReady,
   input  logic [DATA_W-1:0] memData,
   input  logic              flush,
   input  logic              decodeStall,
   output logic              ifidValid,
   output logic [DATA_W-1:0] ifidInstruction,
   output logic [ADDR_W-1:0] ifidPc,
   output logic [ADDR_W-1:0] ifidPcPlus4
);

   fetch_state_t      r_state, w_next;
   logic [ADDR_W-1:0] r_memAddr;
   logic [ADDR_W-1:0] r_skidPc;
   logic [DATA_W-1:0] r_skidInstr;

   logic              w_accept;
   logic              w_toSkid;
   logic              w_load;
   logic [DATA_W-1:0] w_loadInstr;
   logic [ADDR_W-1:0] w_loadPc;

   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_toSkid    = 1'b0;
      w_load      = 1'b0;
      w_loadInstr = memData;
      w_loadPc    = r_memAddr;
      case (r_state)
         S_IDLE: begin
            if (!flush) w_next = S_REQUEST;
         end
         S_REQUEST: begin
            if (flush) begin
               w_next = memReady ? S_IDLE : S_DRAIN;
            end else if (memReady) begin
               w_accept = 1'b1;
               if (!ifidValid || !decodeStall) begin
                  w_load = 1'b1;
               end else begin
                  w_toSkid = 1'b1;
                  w_next   = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (flush) begin
               w_next = S_IDLE;
            end else if (!decodeStall) begin
               w_load      = 1'b1;
               w_loadInstr = r_skidInstr;
               w_loadPc    = r_skidPc;
               w_next      = S_REQUEST;
            end
         end
         S_DRAIN: begin
            // The outstanding response is consumed and dropped, flush or not.
            if (memReady) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Skid occupancy is implied by S_HOLD, so leaving that state empties it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_memAddr   <= '0;
         r_skidPc    <= '0;
         r_skidInstr <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && !flush) begin
            r_memAddr <= pcAddress;
         end else if (w_accept) begin
            r_memAddr <= r_memAddr + ADDR_W'(INSTR_BYTES);
         end
         if (w_toSkid) begin
            r_skidInstr <= memData;
            r_skidPc    <= r_memAddr;
         end
      end
   end

   assign pcAdvance = w_accept & ~reset;
   assign memReq    = (r_state == S_REQUEST) || (r_state == S_DRAIN);
   assign memAddr   = r_memAddr;

   ifid_register #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ifid (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_clear   (flush),
      .i_hold    (decodeStall),
      .i_instr   (w_loadInstr),
      .i_pc      (w_loadPc),
      .o_valid   (ifidValid),
      .o_instr   (ifidInstruction),
      .o_pc      (ifidPc),
      .o_pcPlus4 (ifidPcPlus4)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic
// compared against a transaction-level model of the fetch stage.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset, memReady, flush, decodeStall;
   logic [31:0] pcAddress, memData;
   logic        pcAdvance, memReq, ifidValid;
   logic [31:0] memAddr, ifidInstruction, ifidPc, ifidPcPlus4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instruction_fetch #(
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pcAddress       (pcAddress),
      .pcAdvance       (pcAdvance),
      .memReq          (memReq),
      .memAddr         (memAddr),
      .memReady        (memReady),
      .memData         (memData),
      .flush           (flush),
      .decodeStall     (decodeStall),
      .ifidValid       (ifidValid),
      .ifidInstruction (ifidInstruction),
      .ifidPc          (ifidPc),
      .ifidPcPlus4     (ifidPcPlus4)
   );

   // Model: a request is either outstanding (m_wait), being thrown away (m_disc),
   // or parked behind a stalled decode (m_skid); none of these means "about to fetch".
   bit          m_wait = 0, m_disc = 0, m_skid = 0, m_iv = 0;
   logic [31:0] m_addr = '0, m_ii = '0, m_ip = '0, m_ip4 = '0, m_sI = '0, m_sP = '0;
   bit          e_adv;

   task automatic settle();
      @(negedge clk);
      e_adv = !reset && !flush && m_wait && !m_disc && memReady;
   endtask

   task automatic advance();
      if (reset) begin
         m_wait = 0; m_disc = 0; m_skid = 0; m_iv = 0;
         m_addr = '0; m_ii = '0; m_ip = '0; m_ip4 = '0;
      end else if (m_wait && m_disc) begin
         if (flush) m_iv = 0;
         if (memReady) begin m_wait = 0; m_disc = 0; end
      end else if (flush) begin
         m_iv = 0; m_skid = 0;
         if (m_wait && !memReady) m_disc = 1;
         else m_wait = 0;
      end else if (!m_wait && !m_skid) begin
         m_addr = pcAddress; m_wait = 1;
      end else if (m_skid) begin
         if (!decodeStall) begin
            m_iv = 1; m_ii = m_sI; m_ip = m_sP; m_ip4 = m_sP + 32'd4;
            m_skid = 0; m_wait = 1;
         end
      end else if (memReady) begin
         if (!m_iv || !decodeStall) begin
            m_iv = 1; m_ii = memData; m_ip = m_addr; m_ip4 = m_addr + 32'd4;
         end else begin
            m_sI = memData; m_sP = m_addr; m_skid = 1; m_wait = 0;
         end
         m_addr = m_addr + 32'd4;
      end else if (!decodeStall) begin
         m_iv = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; memReady = 1; flush = 0; decodeStall = 0;
      pcAddress = 32'h40; memData = $urandom;
      advance(); advance();
      settle();
      total++; if (pcAdvance !== 1'b0) begin bad++; $display("FAIL reset_pcAdvance got=%0h want=0", pcAdvance); end
      total++; if (memReq !== 1'b0) begin bad++; $display("FAIL reset_memReq got=%0h want=0", memReq); end
      total++; if (memAddr !== 32'h0) begin bad++; $display("FAIL reset_memAddr got=%0h want=0", memAddr); end
      total++; if (ifidValid !== 1'b0) begin bad++; $display("FAIL reset_ifidValid got=%0h want=0", ifidValid); end
      total++; if (ifidInstruction !== 32'h0) begin bad++; $display("FAIL reset_instr got=%0h want=0", ifidInstruction); end
      total++; if (ifidPc !== 32'h0) begin bad++; $display("FAIL reset_ifidPc got=%0h want=0", ifidPc); end
      total++; if (ifidPcPlus4 !== 32'h0) begin bad++; $display("FAIL reset_ifidPcPlus4 got=%0h want=0", ifidPcPlus4); end
      advance();
   endtask

   task automatic test_stream();
      pcAddress = 32'h0; reset = 0; memReady = 1; decodeStall = 0; flush = 0;
      settle();
      total++; if (memReq !== 1'b0) begin bad++; $display("FAIL stream_idle_memReq got=%0h want=0", memReq); end
      advance();
      for (int k = 0; k < 6; k++) begin
         memData = 32'(4 * k);
         settle();
         total++; if (memReq !== 1'b1) begin bad++; $display("FAIL stream_memReq k=%0d got=%0h want=1", k, memReq); end
         total++; if (memAddr !== 32'(4 * k)) begin bad++; $display("FAIL stream_memAddr k=%0d got=%0h want=%0h", k, memAddr, 4 * k); end
         total++; if (pcAdvance !== 1'b1) begin bad++; $display("FAIL stream_pcAdvance k=%0d got=%0h want=1", k, pcAdvance); end
         if (k > 0) begin
            total++; if (ifidValid !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%0h want=1", k, ifidValid); end
            total++; if (ifidPc !== 32'(4 * (k - 1))) begin bad++; $display("FAIL stream_ifidPc k=%0d got=%0h want=%0h", k, ifidPc, 4 * (k - 1)); end
            total++; if (ifidPcPlus4 !== 32'(4 * k)) begin bad++; $display("FAIL stream_pcPlus4 k=%0d got=%0h want=%0h", k, ifidPcPlus4, 4 * k); end
            total++; if (ifidInstruction !== 32'(4 * (k - 1))) begin bad++; $display("FAIL stream_instr k=%0d got=%0h want=%0h", k, ifidInstruction, 4 * (k - 1)); end
         end
         advance();
         pcAddress = pcAddress + 32'd4;
      end
   endtask

   task automatic test_latency();
      bit          prevRdy = 1;
      logic [31:0] lastData = 32'd20;
      int          validCount = 0;
      for (int j = 0; j < 10; j++) begin
         memReady = (j % 3 == 2) && (j < 9);
         memData  = $urandom;
         settle();
         total++; if (memReq !== 1'b1) begin bad++; $display("FAIL lat_memReq j=%0d got=%0h want=1", j, memReq); end
         total++; if (memAddr !== 32'(24 + 4 * (j / 3))) begin bad++; $display("FAIL lat_memAddr j=%0d got=%0h want=%0h", j, memAddr, 24 + 4 * (j / 3)); end
         total++; if (pcAdvance !== memReady) begin bad++; $display("FAIL lat_pcAdvance j=%0d got=%0h want=%0h", j, pcAdvance, memReady); end
         total++; if (ifidValid !== prevRdy) begin bad++; $display("FAIL lat_valid j=%0d got=%0h want=%0h", j, ifidValid, prevRdy); end
         if (prevRdy) begin
            total++; if (ifidInstruction !== lastData) begin bad++; $display("FAIL lat_instr j=%0d got=%0h want=%0h", j, ifidInstruction, lastData); end
         end
         if (j > 0 && ifidValid === 1'b1) validCount++;
         prevRdy = memReady; lastData = memData;
         advance();
      end
      total++; if (validCount !== 3) begin bad++; $display("FAIL lat_valid_count got=%0d want=3", validCount); end
   endtask

   task automatic test_stall_skid();
      reset = 1; memReady = 0; flush = 0; decodeStall = 0; pcAddress = 32'h8;
      advance();
      reset = 0;
      advance();
      memReady = 1; memData = 32'hA000_0008; advance();
      memData = 32'hA000_000C; advance();
      memData = 32'hA000_0010; decodeStall = 1;
      settle();
      total++; if (memAddr !== 32'h10) begin bad++; $display("FAIL skid_addr got=%0h want=10", memAddr); end
      total++; if (pcAdvance !== 1'b1) begin bad++; $display("FAIL skid_accept got=%0h want=1", pcAdvance); end
      total++; if (ifidPc !== 32'hC) begin bad++; $display("FAIL skid_full_pc got=%0h want=c", ifidPc); end
      advance();
      memData = 32'hDEAD_BEEF;
      for (int s = 0; s < 3; s++) begin
         settle();
         total++; if (memReq !== 1'b0) begin bad++; $display("FAIL skid_hold_memReq s=%0d got=%0h want=0", s, memReq); end
         total++; if (pcAdvance !== 1'b0) begin bad++; $display("FAIL skid_hold_adv s=%0d got=%0h want=0", s, pcAdvance); end
         total++; if (ifidValid !== 1'b1 || ifidPc !== 32'hC) begin bad++; $display("FAIL skid_hold_ifid s=%0d got=%0h/%0h want=1/c", s, ifidValid, ifidPc); end
         advance();
      end
      decodeStall = 0; memReady = 0;
      settle();
      total++; if (memReq !== 1'b0) begin bad++; $display("FAIL skid_release_memReq got=%0h want=0", memReq); end
      advance();
      settle();
      total++; if (ifidValid !== 1'b1 || ifidPc !== 32'h10) begin bad++; $display("FAIL skid_out_pc got=%0h/%0h want=1/10", ifidValid, ifidPc); end
      total++; if (ifidInstruction !== 32'hA000_0010) begin bad++; $display("FAIL skid_out_instr got=%0h want=a0000010", ifidInstruction); end
      total++; if (ifidPcPlus4 !== 32'h14) begin bad++; $display("FAIL skid_out_pc4 got=%0h want=14", ifidPcPlus4); end
      total++; if (memReq !== 1'b1 || memAddr !== 32'h14) begin bad++; $display("FAIL skid_resume got=%0h/%0h want=1/14", memReq, memAddr); end
      advance();
   endtask

   task automatic test_flush_outstanding();
      memReady = 0; flush = 1; pcAddress = 32'h100;
      settle();
      total++; if (pcAdvance !== 1'b0) begin bad++; $display("FAIL fo_adv got=%0h want=0", pcAdvance); end
      advance();
      flush = 0;
      settle();
      total++; if (memReq !== 1'b1 || memAddr !== 32'h14) begin bad++; $display("FAIL fo_drain_req got=%0h/%0h want=1/14", memReq, memAddr); end
      total++; if (ifidValid !== 1'b0) begin bad++; $display("FAIL fo_drain_valid got=%0h want=0", ifidValid); end
      advance();
      memReady = 1; memData = 32'hBAD0_0000;
      settle();
      total++; if (pcAdvance !== 1'b0) begin bad++; $display("FAIL fo_late_adv got=%0h want=0", pcAdvance); end
      advance();
      memReady = 0;
      settle();
      total++; if (memReq !== 1'b0 || ifidValid !== 1'b0) begin bad++; $display("FAIL fo_idle got=%0h/%0h want=0/0", memReq, ifidValid); end
      advance();
      memReady = 1; memData = 32'h1234_5678;
      settle();
      total++; if (memReq !== 1'b1 || memAddr !== 32'h100) begin bad++; $display("FAIL fo_target got=%0h/%0h want=1/100", memReq, memAddr); end
      advance();
      pcAddress = 32'h104; memReady = 0;
      settle();
      total++; if (ifidValid !== 1'b1 || ifidPc !== 32'h100) begin bad++; $display("FAIL fo_ifid got=%0h/%0h want=1/100", ifidValid, ifidPc); end
      advance();
   endtask

   task automatic test_flush_same_cycle();
      memReady = 1; flush = 1; pcAddress = 32'h200; memData = 32'hBAD1_0000;
      settle();
      total++; if (pcAdvance !== 1'b0) begin bad++; $display("FAIL fs_adv got=%0h want=0", pcAdvance); end
      advance();
      flush = 0;
      settle();
      total++; if (memReq !== 1'b0 || ifidValid !== 1'b0) begin bad++; $display("FAIL fs_idle got=%0h/%0h want=0/0", memReq, ifidValid); end
      advance();
      memData = 32'h0000_0200;
      settle();
      total++; if (memReq !== 1'b1 || memAddr !== 32'h200 || pcAdvance !== 1'b1) begin bad++; $display("FAIL fs_target got=%0h/%0h/%0h want=1/200/1", memReq, memAddr, pcAdvance); end
      advance();
      settle();
      total++; if (ifidPc !== 32'h200 || ifidInstruction !== 32'h200) begin bad++; $display("FAIL fs_ifid got=%0h/%0h want=200/200", ifidPc, ifidInstruction); end
      advance();
   endtask

   task automatic test_wrap_and_reset();
      memReady = 1; flush = 1; pcAddress = 32'hFFFF_FFF8;
      advance();
      flush = 0;
      advance();
      advance();
      settle();
      total++; if (memAddr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%0h want=fffffffc", memAddr); end
      advance();
      settle();
      total++; if (memAddr !== 32'h0) begin bad++; $display("FAIL wrap_memAddr got=%0h want=0", memAddr); end
      total++; if (ifidPc !== 32'hFFFF_FFFC || ifidPcPlus4 !== 32'h0) begin bad++; $display("FAIL wrap_ifid got=%0h/%0h want=fffffffc/0", ifidPc, ifidPcPlus4); end
      advance();
      reset = 1;
      settle();
      total++; if (pcAdvance !== 1'b0) begin bad++; $display("FAIL midreset_adv got=%0h want=0", pcAdvance); end
      advance();
      settle();
      total++; if (memReq !== 1'b0 || memAddr !== 32'h0) begin bad++; $display("FAIL midreset_mem got=%0h/%0h want=0/0", memReq, memAddr); end
      total++; if (ifidValid !== 1'b0 || ifidInstruction !== 32'h0) begin bad++; $display("FAIL midreset_ifid got=%0h/%0h want=0/0", ifidValid, ifidInstruction); end
      total++; if (ifidPc !== 32'h0 || ifidPcPlus4 !== 32'h0) begin bad++; $display("FAIL midreset_pc got=%0h/%0h want=0/0", ifidPc, ifidPcPlus4); end
      advance();
      reset = 0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         reset       = ($urandom_range(0, 199) == 0);
         memReady    = ($urandom_range(0, 2) != 0);
         decodeStall = ($urandom_range(0, 9) < 3);
         flush       = ($urandom_range(0, 19) == 0);
         memData     = $urandom;
         settle();
         total++; if (pcAdvance !== e_adv) begin bad++; $display("FAIL rnd_adv c=%0d got=%0h want=%0h", c, pcAdvance, e_adv); end
         total++; if (memReq !== m_wait) begin bad++; $display("FAIL rnd_memReq c=%0d got=%0h want=%0h", c, memReq, m_wait); end
         total++; if (memAddr !== m_addr) begin bad++; $display("FAIL rnd_memAddr c=%0d got=%0h want=%0h", c, memAddr, m_addr); end
         total++; if (ifidValid !== m_iv) begin bad++; $display("FAIL rnd_valid c=%0d got=%0h want=%0h", c, ifidValid, m_iv); end
         total++; if (ifidInstruction !== m_ii) begin bad++; $display("FAIL rnd_instr c=%0d got=%0h want=%0h", c, ifidInstruction, m_ii); end
         total++; if (ifidPc !== m_ip) begin bad++; $display("FAIL rnd_pc c=%0d got=%0h want=%0h", c, ifidPc, m_ip); end
         total++; if (ifidPcPlus4 !== m_ip4) begin bad++; $display("FAIL rnd_pc4 c=%0d got=%0h want=%0h", c, ifidPcPlus4, m_ip4); end
         advance();
         if (flush) pcAddress = $urandom;
         else if (e_adv) pcAddress = pcAddress + 32'd4;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_latency();
      test_stall_skid();
      test_flush_outstanding();
      test_flush_same_cycle();
      test_wrap_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
